// File: rtl/pipe_chain.sv
// Parametrised pipeline register chain: per-stage valid bits, bubble-collapsing
// backpressure, per-stage flush, and full tap export for hazard/forwarding logic.
module pipe_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH-1:0]       tap_valid,
    output logic [DEPTH*WIDTH-1:0] tap_data,
    output logic [CW-1:0]          count
);

    // Stage 0 is the output side, stage DEPTH-1 the input side.
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;

    logic [DEPTH-1:0]            ev;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            src_v;
    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [CW-1:0]               cnt;

    // A flushed item is a bubble in the same cycle it is killed.
    assign ev = v & ~flush;

    // Ready ripples from the output back towards the input.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        rdy    = '0;
        rdy[0] = ~ev[0] | out_ready;
        for (int i = 1; i < DEPTH; i++) begin
            rdy[i] = ~ev[i] | rdy[i-1];
        end
    end

    // What each stage would load if it advanced; bubbles always carry zero data.
    always_comb begin
        src_v            = '0;
        src_d            = '0;
        src_v[DEPTH-1]   = in_valid;
        src_d[DEPTH-1]   = in_valid ? in_data : '0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            src_v[i] = ev[i+1];
            src_d[i] = ev[i+1] ? d[i+1] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, because taps are exported and must read zero.
            v <= '0;
            d <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
                if (rdy[i]) begin
                    v[i] <= src_v[i];
                    d[i] <= src_d[i];
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + CW'(v[i]);
        end
    end

    assign in_ready  = rdy[DEPTH-1];
    assign out_valid = ev[0];
    assign out_data  = d[0];
    assign tap_valid = v;
    assign tap_data  = d;
    assign count     = cnt;

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain (DEPTH=4, WIDTH=32): scoreboard of accepted
// items checked in order at the output, plus directed flush/backpressure/reset tasks.
module tb_pipe_chain;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic [WIDTH-1:0]       in_data;
    logic                   in_ready;
    logic                   out_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_ready;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH-1:0]       tap_valid;
    logic [DEPTH*WIDTH-1:0] tap_data;
    logic [CW-1:0]          count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] sb[$];

    pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .tap_valid (tap_valid),
        .tap_data  (tap_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: handshakes sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected_out: got %h, expected no output", out_data);
                end else begin
                    logic [WIDTH-1:0] exp_d;
                    exp_d = sb.pop_front();
                    if (out_data !== exp_d) begin
                        n_bad++;
                        $display("FAIL sb_out_data: got %h, expected %h", out_data, exp_d);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // A flushed item must never come out, so drop it from the expected stream.
    task automatic kill(input logic [WIDTH-1:0] val);
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i] == val) begin
                sb.delete(i);
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = '0;
        repeat (n) cyc();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_sb_empty: %0d items left, expected 0", sb.size());
        end
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_empty: count=%0d out_valid=%b, expected 0/0", count, out_valid);
        end
    endtask

    // Empty chain, out_ready=0: four pushes leave base at stage 0 ... base+3 at stage 3.
    task automatic fill4(input logic [WIDTH-1:0] base);
        out_ready = 1'b0;
        flush     = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = base + WIDTH'(i);
            cyc();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== '0 || count !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_outputs: ov=%b od=%h cnt=%0d ir=%b, expected 0/0/0/1",
                     out_valid, out_data, count, in_ready);
        end
        n_cmp++;
        if (tap_valid !== '0 || tap_data !== '0) begin
            n_bad++;
            $display("FAIL reset_taps: tv=%b td=%h, expected 0/0", tap_valid, tap_data);
        end
        #9 rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_latency();
        int peak;
        peak      = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cyc();
        for (int j = 0; j < 3; j++) begin
            if (j == 0) in_data = 32'h22;
            if (j == 1) in_data = 32'h33;
            if (j == 2) in_valid = 1'b0;
            if (int'(count) > peak) peak = int'(count);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL latency_early: out_valid=%b after edge %0d, expected 0", out_valid, j);
            end
            cyc();
        end
        if (int'(count) > peak) peak = int'(count);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h11) begin
            n_bad++;
            $display("FAIL latency_first: ov=%b od=%h, expected 1/00000011", out_valid, out_data);
        end
        for (int j = 0; j < 4; j++) begin
            cyc();
            if (int'(count) > peak) peak = int'(count);
        end
        n_cmp++;
        if (peak != 3) begin
            n_bad++;
            $display("FAIL latency_peak_count: got %0d, expected 3", peak);
        end
        drain(4);
    endtask

    task automatic test_backpressure();
        fill4(32'h101);
        in_valid = 1'b1;
        in_data  = 32'h105;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || count !== CW'(4)) begin
            n_bad++;
            $display("FAIL bp_full: in_ready=%b count=%0d, expected 0/4", in_ready, count);
        end
        n_cmp++;
        if (tap_data !== {32'h104, 32'h103, 32'h102, 32'h101} || tap_valid !== 4'hF) begin
            n_bad++;
            $display("FAIL bp_taps: td=%h tv=%b, expected 00000104000001030000010200000101/1111",
                     tap_data, tap_valid);
        end
        cyc();
        n_cmp++;
        if (in_ready !== 1'b0 || count !== CW'(4)) begin
            n_bad++;
            $display("FAIL bp_hold: in_ready=%b count=%0d, expected 0/4", in_ready, count);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release_ready: in_ready=%b, expected 1", in_ready);
        end
        cyc();
        drain(6);
    endtask

    task automatic test_flush_mid();
        fill4(32'h201);
        flush    = 4'b0100;
        in_valid = 1'b1;
        in_data  = 32'h205;
        kill(32'h203);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_mid_ready: in_ready=%b, expected 1", in_ready);
        end
        cyc();
        n_cmp++;
        if (tap_data !== {32'h205, 32'h204, 32'h202, 32'h201} || count !== CW'(4)) begin
            n_bad++;
            $display("FAIL flush_mid_in: td=%h cnt=%0d, expected 00000205000002040000020200000201/4",
                     tap_data, count);
        end
        flush    = 4'b0100;
        in_valid = 1'b0;
        kill(32'h204);
        cyc();
        flush = '0;
        n_cmp++;
        if (tap_data !== {32'h0, 32'h205, 32'h202, 32'h201} || count !== CW'(3) || tap_valid !== 4'b0111) begin
            n_bad++;
            $display("FAIL flush_mid_noin: td=%h cnt=%0d tv=%b, expected 00000000000002050000020200000201/3/0111",
                     tap_data, count, tap_valid);
        end
        drain(6);
    endtask

    task automatic test_flush_out();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAA;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'hAA || count !== CW'(1)) begin
            n_bad++;
            $display("FAIL flush_out_setup: ov=%b od=%h cnt=%0d, expected 1/000000aa/1",
                     out_valid, out_data, count);
        end
        flush = 4'b0001;
        kill(32'hAA);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_out_same_cycle: out_valid=%b, expected 0", out_valid);
        end
        cyc();
        flush = '0;
        n_cmp++;
        if (tap_valid[0] !== 1'b0 || tap_data[WIDTH-1:0] !== '0 || count !== '0) begin
            n_bad++;
            $display("FAIL flush_out_after: v0=%b d0=%h cnt=%0d, expected 0/0/0",
                     tap_valid[0], tap_data[WIDTH-1:0], count);
        end
        drain(2);
    endtask

    task automatic test_bubble_collapse();
        fill4(32'h301);
        flush    = 4'b0010;
        in_valid = 1'b1;
        in_data  = 32'h305;
        kill(32'h302);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL collapse_ready: in_ready=%b out_valid=%b, expected 1/1", in_ready, out_valid);
        end
        cyc();
        flush    = '0;
        in_valid = 1'b0;
        n_cmp++;
        if (tap_data !== {32'h305, 32'h304, 32'h303, 32'h301} || count !== CW'(4)) begin
            n_bad++;
            $display("FAIL collapse_taps: td=%h cnt=%0d, expected 00000305000003040000030300000301/4",
                     tap_data, count);
        end
        drain(6);
    endtask

    task automatic test_async_reset();
        int lat;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h401 + WIDTH'(i);
            cyc();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (count !== CW'(3)) begin
            n_bad++;
            $display("FAIL areset_pre_count: got %0d, expected 3", count);
        end
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        n_cmp++;
        if (count !== '0 || out_valid !== 1'b0 || tap_data !== '0 || tap_valid !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL areset_immediate: cnt=%0d ov=%b td=%h tv=%b ir=%b, expected 0/0/0/0/1",
                     count, out_valid, tap_data, tap_valid, in_ready);
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h4E1;
        cyc();
        in_valid = 1'b0;
        lat      = 1;
        while (out_valid !== 1'b1 && lat < 12) begin
            cyc();
            lat++;
        end
        n_cmp++;
        if (lat != DEPTH) begin
            n_bad++;
            $display("FAIL areset_latency: first output after %0d edges, expected %0d", lat, DEPTH);
        end
        drain(4);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end
        drain(8);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = '0;
        test_reset();
        test_latency();
        test_backpressure();
        test_flush_mid();
        test_flush_out();
        test_bubble_collapse();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised pipeline register chain with per-stage valid bits, bubble-collapsing backpressure and per-stage kill (flush).
- Successor to the fixed enable/reset shift chain. Carries WIDTH-bit payloads through DEPTH stages.
- Valid/ready handshake on both ends.
- All stage contents are exported as taps for hazard/forwarding logic in the rv32 core pipeline.

Parameters:
- WIDTH, 32, payload width in bits.
- DEPTH, 4, number of stages (>=1). Stage DEPTH-1 is the input side; stage 0 is the output side.
- CW, $clog2(DEPTH+1), occupancy count width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream item present.
- in_data  in  WIDTH  upstream payload.
- in_ready  out  1  chain accepts in_data this cycle.
- out_valid  out  1  stage 0 holds a live item.
- out_data  out  WIDTH  stage 0 payload.
- out_ready  in  1  downstream accepts stage 0 this cycle.
- flush  in  DEPTH  bit i kills the item currently held in stage i.
- tap_valid  out  DEPTH  registered valid of every stage (pre-flush).
- tap_data  out  DEPTH*WIDTH  registered payload of every stage; stage i occupies bits [i*WIDTH +: WIDTH].
- count  out  CW  popcount of tap_valid.

Behaviour:
- State per stage i: v[i] (1 bit), d[i] (WIDTH bits).
- Reset: rst_n low clears all v and d to 0 asynchronously. Consequently out_valid=0, out_data=0, count=0, in_ready=1.
- Effective valid: ev[i] = v[i] & ~flush[i]. A flushed item is treated as a bubble in the same cycle.
- Ready chain (combinational):
  - rdy[0] = ~ev[0] | out_ready.
  - rdy[i] = ~ev[i] | rdy[i-1].
  - in_ready = rdy[DEPTH-1].
  - Combinational paths flush->in_ready and out_ready->in_ready are permitted and required.
- Outputs: out_valid = ev[0]; out_data = d[0] (not masked by flush).
- Stage update at posedge, stage i < DEPTH-1:
  - If rdy[i]: v[i] <= ev[i+1]; d[i] <= ev[i+1] ? d[i+1] : 0.
  - Else hold (this implies ev[i]=1, so the stage cannot be flushed while holding).
- Stage DEPTH-1:
  - If rdy[DEPTH-1]: v <= in_valid; d <= in_valid ? in_data : 0.
  - Else hold.
- Bubbles always carry zero data. A flushed item is never transferred downstream and never appears on out_valid.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_data is ignored when in_valid=0.
- Latency and throughput:
  - An item accepted at edge k with no stalls is presented on out_valid after edge k+DEPTH-1. That is DEPTH cycles from the input handshake cycle to the output handshake cycle.
  - Throughput is 1 item/cycle when out_ready=1.
- Bubble collapse: any empty or flushed stage lets the upstream items advance even while out_ready=0. A full chain with out_ready=0 drives in_ready=0.
- Flush:
  - Multiple bits may be set.
  - flush[i] together with out_ready=0 still empties stage i at the next edge, provided stage i is reloaded from upstream. Stage i then receives ev[i+1], or a bubble.
  - flush bits on already-empty stages have no effect.
  - flush = all ones: every stage accepts from upstream this cycle, so the chain ends holding only the new input (if in_valid).
- count reflects registered v (pre-flush) and is valid in the same cycle.
- DEPTH=1: the chain degenerates to a single skid-less register stage with the same rules.
- Reset asserted mid-transfer: all contents are lost. No handshake completes on that edge.

Test Plan:
- DEPTH=4, WIDTH=32, out_ready=1, in_valid=1 with 0x11,0x22,0x33 on consecutive cycles -> out_valid first high 4 cycles after 0x11 is accepted; outputs in order 0x11,0x22,0x33; count peaks at 3.
- out_ready=0, push 5 items -> in_ready drops after the 4th is accepted; count=4; tap_data = {1st at stage0 ... 4th at stage3}. Raise out_ready -> 5th is accepted the same cycle, and items drain in order.
- Chain full, out_ready=0, flush=4'b0100 -> at the next edge, stage 2 holds the old stage 3 item; stage 3 takes the input if in_valid; the killed item never reaches out_valid; count stays 4 if in_valid, else 3.
- Single item 0xAA in stage 0, out_ready=0, flush=4'b0001 -> out_valid=0 that cycle; after the edge v[0]=0 and d[0]=0 (no upstream item); count=0.
- Chain full, out_ready=0, gap in stage 1 created by flushing it -> at the next edge, items in stages 2 and 3 shift down (bubble collapse) while stage 0 holds; in_ready=1 during the flush cycle.
- rst_n asserted asynchronously mid-stream with count=3 -> count=0, out_valid=0, tap_data=0 immediately without waiting for a clock edge; after release, the first new item sees the full DEPTH-cycle latency.
